// File: rtl/maxpool2_stream_3x3s2.sv
// Streaming 3x3 / stride-2 signed max-pool over raster-ordered channel planes.
// Row partial maxima live in hacc, column partial maxima in vbuf; one output register.
module maxpool2_stream_3x3s2 #(
  parameter int DATA_W   = 16,
  parameter int IN_W     = 27,
  parameter int CHANNELS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last_plane,
  output logic              out_last
);
  localparam int OUT_W = (IN_W - 3) / 2 + 1;
  localparam int CW    = $clog2(IN_W);
  localparam int KW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CW-1:0]     col_q, col_d, row_q, row_d;
  logic [CHW-1:0]    chan_q, chan_d;
  logic [KW-1:0]     k_q;
  logic [DATA_W-1:0] hacc_q;
  logic [DATA_W-1:0] vbuf_q [OUT_W];
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_last_plane_q, out_last_q;

  logic              accept, col_last, row_last, chan_last;
  logic              h_vld, emit;
  logic [DATA_W-1:0] h, vmax;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign in_ready  = !out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign col_last  = (col_q == CW'(IN_W - 1));
  assign row_last  = (row_q == CW'(IN_W - 1));
  assign chan_last = (chan_q == CHW'(CHANNELS - 1));

  // A horizontal window closes on every even column past 0; k_q tracks its index.
  assign h     = smax(hacc_q, in_data);
  assign h_vld = accept & !col_q[0] & (col_q != '0);
  assign vmax  = smax(vbuf_q[k_q], h);
  assign emit  = h_vld & !row_q[0] & (row_q != '0);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    chan_d = chan_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d  = '0;
          chan_d = chan_last ? '0 : chan_q + CHW'(1);
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q            <= '0;
      row_q            <= '0;
      chan_q           <= '0;
      k_q              <= '0;
      hacc_q           <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_last_plane_q <= 1'b0;
      out_last_q       <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      chan_q <= chan_d;
      if (accept) hacc_q <= col_q[0] ? h : in_data;
      if (h_vld)  k_q    <= col_last ? '0 : k_q + KW'(1);
      if (emit) begin
        out_valid_q      <= 1'b1;
        out_data_q       <= vmax;
        out_last_plane_q <= col_last & row_last;
        out_last_q       <= col_last & row_last & chan_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Row 0 of every plane overwrites its slot before any read, so no reset needed.
  always_ff @(posedge clk) begin
    if (h_vld) vbuf_q[k_q] <= row_q[0] ? vmax : h;
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last_plane = out_last_plane_q;
  assign out_last       = out_last_q;
endmodule

// File: tb/tb_maxpool2_stream_3x3s2.sv
// Scoreboard bench for maxpool2_stream_3x3s2: a window-max model fills the
// expected queue per plane, a negedge monitor collects output beats.
module tb_maxpool2_stream_3x3s2;
  localparam int N  = 27;
  localparam int NO = 13;
  localparam int NP = NO * NO;

  typedef struct packed {
    logic [15:0] d;
    logic        lp;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last_plane;
  logic        out_last;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int ready_err = 0;
  int stall_seen = 0;

  beat_t       expq[$];
  beat_t       rxq[$];
  logic [15:0] pl [N][N];

  maxpool2_stream_3x3s2 #(.DATA_W(16), .IN_W(N), .CHANNELS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_plane(out_last_plane), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) rxq.push_back('{out_data, out_last_plane, out_last});
      if (in_valid && in_ready) acc_cnt++;
      if (in_ready !== (!out_valid || out_ready)) ready_err++;
      if (!in_ready) stall_seen++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expq.delete();
    rxq.delete();
    acc_cnt = 0;
    ready_err = 0;
    stall_seen = 0;
  endtask

  task automatic fill_ramp(input int off);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) pl[r][c] = 16'(r * N + c + off);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) pl[r][c] = v;
  endtask

  // Reference: direct 3x3 signed window max over the current plane.
  task automatic push_exp(input int ch);
    beat_t b;
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NO; c++) begin
        int m;
        m = -100000;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (int'($signed(pl[2*r+i][2*c+j])) > m) m = int'($signed(pl[2*r+i][2*c+j]));
        b.d    = 16'(m);
        b.lp   = (r == NO-1) && (c == NO-1);
        b.last = b.lp && (ch == 2);
        expq.push_back(b);
      end
  endtask

  task automatic drive_plane(input bit gaps, input int nmax);
    int n;
    n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (n < nmax) begin
          bit a;
          int guard;
          if (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          in_valid = 1'b1;
          in_data  = pl[r][c];
          guard = 0;
          do begin
            @(negedge clk) a = in_ready;
            @(posedge clk);
            #1;
            guard++;
          end while (!a && guard < 1000);
          n++;
        end
      end
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rxq.size() < n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    if (out_last_plane !== 1'b0) begin bad++; $display("FAIL reset_last_plane got %b want 0", out_last_plane); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got %b want 0", out_last); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ramp();
    do_reset();
    fill_ramp(0);
    push_exp(0);
    drive_plane(1'b0, N*N);
    wait_rx(NP);
    total++;
    if (rxq.size() !== NP) begin bad++; $display("FAIL ramp_count got %0d want %0d", rxq.size(), NP); end
    total++;
    if (rxq.size() != 0 && rxq[0].d !== 16'd56) begin bad++; $display("FAIL ramp_first got %0d want 56", rxq[0].d); end
    total++;
    if (rxq.size() >= NP && rxq[NP-1].d !== 16'd728) begin bad++; $display("FAIL ramp_last got %0d want 728", rxq[NP-1].d); end
    for (int i = 0; i < expq.size(); i++) begin
      beat_t act;
      act = (i < rxq.size()) ? rxq[i] : 'x;
      total++;
      if (act !== expq[i]) begin bad++; $display("FAIL ramp beat %0d got %h want %h", i, act, expq[i]); end
    end
  endtask

  task automatic test_signed();
    do_reset();
    fill_const(16'hFFFF);
    pl[0][0] = 16'h7FFF;
    push_exp(0);
    drive_plane(1'b0, N*N);
    fill_const(16'h8000);
    pl[N-1][N-1] = 16'h0000;
    push_exp(1);
    drive_plane(1'b0, N*N);
    wait_rx(2*NP);
    total++;
    if (rxq.size() !== 2*NP) begin bad++; $display("FAIL signed_count got %0d want %0d", rxq.size(), 2*NP); end
    total++;
    if (rxq.size() > 1 && (rxq[0].d !== 16'h7FFF || rxq[1].d !== 16'hFFFF))
      begin bad++; $display("FAIL signed_pos got %h/%h want 7fff/ffff", rxq[0].d, rxq[1].d); end
    total++;
    if (rxq.size() >= 2*NP && (rxq[2*NP-1].d !== 16'h0000 || rxq[2*NP-2].d !== 16'h8000))
      begin bad++; $display("FAIL signed_neg got %h/%h want 0000/8000", rxq[2*NP-1].d, rxq[2*NP-2].d); end
    for (int i = 0; i < expq.size(); i++) begin
      beat_t act;
      act = (i < rxq.size()) ? rxq[i] : 'x;
      total++;
      if (act !== expq[i]) begin bad++; $display("FAIL signed beat %0d got %h want %h", i, act, expq[i]); end
    end
  endtask

  task automatic test_overlap();
    do_reset();
    fill_const(16'h0000);
    pl[2][2] = 16'd100;
    push_exp(0);
    drive_plane(1'b0, N*N);
    wait_rx(NP);
    total++;
    if (rxq.size() !== NP) begin bad++; $display("FAIL overlap_count got %0d want %0d", rxq.size(), NP); end
    total++;
    if (rxq.size() >= NP && (rxq[0].d !== 16'd100 || rxq[1].d !== 16'd100 || rxq[NO].d !== 16'd100 ||
        rxq[NO+1].d !== 16'd100 || rxq[2].d !== 16'd0))
      begin bad++; $display("FAIL overlap_corner got %0d %0d %0d %0d %0d want 100 100 100 100 0",
                            rxq[0].d, rxq[1].d, rxq[NO].d, rxq[NO+1].d, rxq[2].d); end
    for (int i = 0; i < expq.size(); i++) begin
      beat_t act;
      act = (i < rxq.size()) ? rxq[i] : 'x;
      total++;
      if (act !== expq[i]) begin bad++; $display("FAIL overlap beat %0d got %h want %h", i, act, expq[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fill_ramp(0);
    push_exp(0);
    fork
      drive_plane(1'b1, N*N);
      begin
        int t;
        t = 0;
        while (acc_cnt < 200 && t < 5000) begin
          @(posedge clk);
          t++;
        end
        #1 out_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_rx(NP);
    total++;
    if (rxq.size() !== NP) begin bad++; $display("FAIL stall_count got %0d want %0d", rxq.size(), NP); end
    total++;
    if (ready_err !== 0) begin bad++; $display("FAIL stall_in_ready got %0d bad cycles want 0", ready_err); end
    total++;
    if (stall_seen == 0) begin bad++; $display("FAIL stall_backpressure got %0d stall cycles want >0", stall_seen); end
    for (int i = 0; i < expq.size(); i++) begin
      beat_t act;
      act = (i < rxq.size()) ? rxq[i] : 'x;
      total++;
      if (act !== expq[i]) begin bad++; $display("FAIL stall beat %0d got %h want %h", i, act, expq[i]); end
    end
  endtask

  task automatic test_channels();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      fill_ramp(p * 1000);
      push_exp(p);
      drive_plane(1'b0, N*N);
    end
    wait_rx(3*NP);
    total++;
    if (rxq.size() !== 3*NP) begin bad++; $display("FAIL chan_count got %0d want %0d", rxq.size(), 3*NP); end
    total++;
    if (rxq.size() > NP && rxq[NP].d !== 16'd1056) begin bad++; $display("FAIL chan_beat170 got %0d want 1056", rxq[NP].d); end
    total++;
    if (rxq.size() >= 3*NP && (rxq[3*NP-1].last !== 1'b1 || rxq[2*NP-1].last !== 1'b0 || rxq[2*NP-1].lp !== 1'b1))
      begin bad++; $display("FAIL chan_last got last507=%b last338=%b lp338=%b want 1 0 1",
                            rxq[3*NP-1].last, rxq[2*NP-1].last, rxq[2*NP-1].lp); end
    for (int i = 0; i < expq.size(); i++) begin
      beat_t act;
      act = (i < rxq.size()) ? rxq[i] : 'x;
      total++;
      if (act !== expq[i]) begin bad++; $display("FAIL chan beat %0d got %h want %h", i, act, expq[i]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill_ramp(0);
    drive_plane(1'b0, 100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    rxq.delete();
    expq.delete();
    push_exp(0);
    drive_plane(1'b0, N*N);
    wait_rx(NP);
    total++;
    if (rxq.size() !== NP) begin bad++; $display("FAIL midrst_count got %0d want %0d", rxq.size(), NP); end
    for (int i = 0; i < expq.size(); i++) begin
      beat_t act;
      act = (i < rxq.size()) ? rxq[i] : 'x;
      total++;
      if (act !== expq[i]) begin bad++; $display("FAIL midrst beat %0d got %h want %h", i, act, expq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_overlap();
    test_stall();
    test_channels();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
